// File: rtl/vc_output_arbiter.sv
// ============================================================================
// vc_output_arbiter
// ----------------------------------------------------------------------------
// Collects the per-VC flit channels leaving the VC buffers and arbitrates them
// onto a single output link. Arbitration is round-robin among VCs presenting
// a head or head_tail flit; a VC that wins with a head flit keeps the link
// (wormhole lock) until its tail flit has been accepted. A small FIFO sits
// between the arbiter and the link so that link backpressure does not stall
// the grant logic combinationally.
//
// Flit request word (FLIT_W = 37):
//   [0]      valid
//   [2:1]    vc_id (overwritten with the winning VC on the output side)
//   [36:3]   fdata, whose top two bits [36:35] are the flit type
//            00 head, 01 body, 10 tail, 11 head_tail
//
// Ports:
//   clk          system clock
//   arst         asynchronous reset, active low
//   vc_req_i     per-VC flit words, VC k at [k*FLIT_W +: FLIT_W]
//   vc_ready_o   per-VC ready, bit k accepts VC k's flit
//   fout_req_o   output link flit word (bit 0 is valid)
//   fout_resp_i  output link ready
// ============================================================================
module vc_output_arbiter #(
    parameter int N_VC       = 3,
    parameter int FLIT_W     = 37,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_VC*FLIT_W-1:0]   vc_req_i,
    output logic [N_VC-1:0]          vc_ready_o,
    output logic [FLIT_W-1:0]        fout_req_o,
    input  logic                     fout_resp_i
);

    localparam int VC_W  = (N_VC > 1) ? $clog2(N_VC) : 1;
    localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    localparam logic [1:0] TYPE_HEAD      = 2'b00;
    localparam logic [1:0] TYPE_BODY      = 2'b01;
    localparam logic [1:0] TYPE_TAIL      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [VC_W-1:0]     lockVc_q, lockVc_d;
    logic [VC_W-1:0]     lastGrant_q, lastGrant_d;

    logic [FLIT_W-1:0]   mem_q [OBUF_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // ------------------------------------------------------------------------
    // Input unpacking
    // ------------------------------------------------------------------------
    logic [FLIT_W-1:0]   vcFlit [N_VC];
    logic [N_VC-1:0]     vcValid;
    logic [N_VC-1:0]     vcEligible;

    for (genvar k = 0; k < N_VC; k++) begin : gUnpack
        assign vcFlit[k]     = vc_req_i[k*FLIT_W +: FLIT_W];
        assign vcValid[k]    = vcFlit[k][0];
        assign vcEligible[k] = vcFlit[k][0] &&
                               ((vcFlit[k][FLIT_W-1 -: 2] == TYPE_HEAD) ||
                                (vcFlit[k][FLIT_W-1 -: 2] == TYPE_HEAD_TAIL));
    end

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
    logic                idleFound;
    logic [VC_W-1:0]     idleSel;
    logic [VC_W-1:0]     selVc;
    logic                selValid;
    logic [FLIT_W-1:0]   selFlit;
    logic [1:0]          selType;
    logic                canAccept;
    logic                accept;
    logic [FLIT_W-1:0]   pushData;
    logic                pop;

    // Round-robin search starting one past the last VC that finished a packet.
    always_comb begin
        idleFound = 1'b0;
        idleSel   = '0;
        for (int i = 0; i < N_VC; i++) begin
            if (!idleFound &&
                vcEligible[VC_W'((int'(lastGrant_q) + 1 + i) % N_VC)]) begin
                idleFound = 1'b1;
                idleSel   = VC_W'((int'(lastGrant_q) + 1 + i) % N_VC);
            end
        end
    end

    // While locked, the owning VC is the only candidate and any valid flit it
    // presents is taken regardless of type.
    always_comb begin
        selVc   = (state_q == LOCKED) ? lockVc_q : idleSel;
        selFlit = '0;
        for (int k = 0; k < N_VC; k++) begin
            if (selVc == VC_W'(k)) begin
                selFlit = vcFlit[k];
            end
        end
        selType  = selFlit[FLIT_W-1 -: 2];
        selValid = (state_q == LOCKED) ? selFlit[0] : idleFound;
    end

    assign canAccept = (count_q < CNT_W'(OBUF_DEPTH));
    assign accept    = selValid && canAccept;

    // Ready is gated by the reset input so that nothing appears ready while
    // the block is held in reset, whatever the upstream presents.
    always_comb begin
        vc_ready_o = '0;
        for (int k = 0; k < N_VC; k++) begin
            vc_ready_o[k] = accept && (selVc == VC_W'(k)) && arst;
        end
    end

    // The stored vc_id is the one we actually granted, not what upstream sent.
    always_comb begin
        pushData      = selFlit;
        pushData[2:1] = 2'(selVc);
    end

    // ------------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lockVc_d    = lockVc_q;
        lastGrant_d = lastGrant_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (selType == TYPE_HEAD) begin
                        state_d  = LOCKED;
                        lockVc_d = selVc;
                    end else if (selType == TYPE_HEAD_TAIL) begin
                        lastGrant_d = selVc;
                    end
                end
                LOCKED: begin
                    // Head or head_tail while locked is a protocol error and
                    // is forwarded like a body flit without releasing the lock.
                    if (selType == TYPE_TAIL) begin
                        state_d     = IDLE;
                        lastGrant_d = lockVc_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= IDLE;
            lockVc_q    <= '0;
            lastGrant_q <= VC_W'(N_VC - 1);
        end else begin
            state_q     <= state_d;
            lockVc_q    <= lockVc_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------------
    assign pop        = (count_q != '0) && fout_resp_i;
    assign fout_req_o = (count_q != '0) ? mem_q[rdPtr_q] : '0;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (accept) begin
            wrPtr_d = (wrPtr_q == PTR_W'(OBUF_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(OBUF_DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                mem_q[wrPtr_q] <= pushData;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// ============================================================================
// tb_vc_output_arbiter
// ----------------------------------------------------------------------------
// Directed testbench for vc_output_arbiter: reset values, round-robin order,
// wormhole locking, output backpressure, orphan body flits and reset in the
// middle of a packet. Expected values are written out by hand.
// ============================================================================
module tb_vc_output_arbiter;

    localparam int N_VC   = 3;
    localparam int FLIT_W = 37;

    localparam logic [1:0] HEAD = 2'b00;
    localparam logic [1:0] BODY = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] HT   = 2'b11;

    logic                   clk;
    logic                   arst;
    logic [N_VC*FLIT_W-1:0] vc_req_i;
    logic [N_VC-1:0]        vc_ready_o;
    logic [FLIT_W-1:0]      fout_req_o;
    logic                   fout_resp_i;

    int assertCount;
    int failCount;

    vc_output_arbiter #(
        .N_VC      (3),
        .FLIT_W    (37),
        .OBUF_DEPTH(2)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .vc_req_i   (vc_req_i),
        .vc_ready_o (vc_ready_o),
        .fout_req_o (fout_req_o),
        .fout_resp_i(fout_resp_i)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds a flit word: type, 32-bit payload, vc_id, valid.
    function automatic logic [FLIT_W-1:0] mkFlit(input logic [1:0] ftype,
                                                 input logic [31:0] payload,
                                                 input logic [1:0] vc);
        return {ftype, payload, vc, 1'b1};
    endfunction

    // Advances to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Places one flit word on a VC's input slice.
    task automatic applyStimulus(input int vc, input logic [FLIT_W-1:0] flit);
        vc_req_i[vc*FLIT_W +: FLIT_W] = flit;
    endtask

    // One comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag,
                               input logic [FLIT_W-1:0] observed,
                               input logic [FLIT_W-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset with random inputs present.
        arst        = 1'b0;
        fout_resp_i = 1'b0;
        vc_req_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
        #2;
        checkOutput("reset_fout", fout_req_o, '0);
        checkOutput("reset_ready", FLIT_W'(vc_ready_o), '0);
        nextCycle();
        vc_req_i = {$urandom(), $urandom(), $urandom(), 32'hFFFF_FFFF};
        fout_resp_i = 1'b1;
        #1;
        checkOutput("reset_ready_rand", FLIT_W'(vc_ready_o), '0);
        checkOutput("reset_fout_rand", fout_req_o, '0);

        // First flit after reset release.
        nextCycle();
        arst     = 1'b1;
        vc_req_i = '0;
        applyStimulus(0, mkFlit(HT, 32'h1234, 2'b11));
        #1;
        checkOutput("first_ready", FLIT_W'(vc_ready_o), FLIT_W'(3'b001));
        nextCycle();
        checkOutput("first_fout", fout_req_o, mkFlit(HT, 32'h1234, 2'd0));
        vc_req_i = '0;
        #1;
        checkOutput("first_ready_idle", FLIT_W'(vc_ready_o), '0);
        nextCycle();
        checkOutput("first_drained", fout_req_o, '0);

        // Round-robin with all three VCs presenting head_tail flits.
        arst = 1'b0;
        #1;
        arst = 1'b1;
        for (int k = 0; k < N_VC; k++) begin
            applyStimulus(k, mkFlit(HT, 32'hA0 + k, 2'b11));
        end
        #1;
        checkOutput("rr_ready0", FLIT_W'(vc_ready_o), FLIT_W'(3'b001));
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            checkOutput($sformatf("rr_fout%0d", i), fout_req_o,
                        mkFlit(HT, 32'hA0 + (i % 3), 2'(i % 3)));
            checkOutput($sformatf("rr_ready%0d", i + 1), FLIT_W'(vc_ready_o),
                        FLIT_W'(3'b001 << ((i + 1) % 3)));
        end
        vc_req_i = '0;
        nextCycle();
        checkOutput("rr_drained", fout_req_o, '0);

        // Wormhole lock on VC1 while VC0 and VC2 wait with head_tail flits.
        applyStimulus(1, mkFlit(HEAD, 32'hB0, 2'b00));
        #1;
        checkOutput("wh_ready_head", FLIT_W'(vc_ready_o), FLIT_W'(3'b010));
        nextCycle();
        checkOutput("wh_fout_head", fout_req_o, mkFlit(HEAD, 32'hB0, 2'd1));
        applyStimulus(0, mkFlit(HT, 32'hC0, 2'b00));
        applyStimulus(2, mkFlit(HT, 32'hC2, 2'b00));
        applyStimulus(1, mkFlit(BODY, 32'hB1, 2'b00));
        #1;
        checkOutput("wh_ready_body1", FLIT_W'(vc_ready_o), FLIT_W'(3'b010));
        nextCycle();
        checkOutput("wh_fout_body1", fout_req_o, mkFlit(BODY, 32'hB1, 2'd1));
        applyStimulus(1, mkFlit(BODY, 32'hB2, 2'b00));
        #1;
        checkOutput("wh_ready_body2", FLIT_W'(vc_ready_o), FLIT_W'(3'b010));
        nextCycle();
        checkOutput("wh_fout_body2", fout_req_o, mkFlit(BODY, 32'hB2, 2'd1));
        applyStimulus(1, mkFlit(TAIL, 32'hB3, 2'b00));
        #1;
        checkOutput("wh_ready_tail", FLIT_W'(vc_ready_o), FLIT_W'(3'b010));
        nextCycle();
        checkOutput("wh_fout_tail", fout_req_o, mkFlit(TAIL, 32'hB3, 2'd1));
        applyStimulus(1, '0);
        #1;
        checkOutput("wh_ready_next", FLIT_W'(vc_ready_o), FLIT_W'(3'b100));
        nextCycle();
        checkOutput("wh_fout_next", fout_req_o, mkFlit(HT, 32'hC2, 2'd2));
        vc_req_i = '0;
        nextCycle();
        checkOutput("wh_drained", fout_req_o, '0);

        // Backpressure with VC2 streaming.
        fout_resp_i = 1'b0;
        applyStimulus(2, mkFlit(HT, 32'hD0, 2'b00));
        #1;
        checkOutput("bp_ready_d0", FLIT_W'(vc_ready_o), FLIT_W'(3'b100));
        nextCycle();
        checkOutput("bp_fout_d0", fout_req_o, mkFlit(HT, 32'hD0, 2'd2));
        applyStimulus(2, mkFlit(HT, 32'hD1, 2'b00));
        #1;
        checkOutput("bp_ready_d1", FLIT_W'(vc_ready_o), FLIT_W'(3'b100));
        nextCycle();
        applyStimulus(2, mkFlit(HT, 32'hD2, 2'b00));
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_ready_full%0d", i), FLIT_W'(vc_ready_o), '0);
            checkOutput($sformatf("bp_fout_hold%0d", i), fout_req_o,
                        mkFlit(HT, 32'hD0, 2'd2));
            nextCycle();
        end
        fout_resp_i = 1'b1;
        #1;
        checkOutput("bp_ready_nobypass", FLIT_W'(vc_ready_o), '0);
        checkOutput("bp_drain_d0", fout_req_o, mkFlit(HT, 32'hD0, 2'd2));
        nextCycle();
        checkOutput("bp_drain_d1", fout_req_o, mkFlit(HT, 32'hD1, 2'd2));
        #1;
        checkOutput("bp_ready_free", FLIT_W'(vc_ready_o), FLIT_W'(3'b100));
        nextCycle();
        checkOutput("bp_drain_d2", fout_req_o, mkFlit(HT, 32'hD2, 2'd2));
        vc_req_i = '0;
        nextCycle();
        checkOutput("bp_drained", fout_req_o, '0);

        // Orphan body flit in IDLE is never granted.
        applyStimulus(0, mkFlit(BODY, 32'hE0, 2'b00));
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("orphan_ready%0d", i), FLIT_W'(vc_ready_o), '0);
            checkOutput($sformatf("orphan_fout%0d", i), fout_req_o, '0);
            nextCycle();
        end

        // Reset in the middle of a VC2 packet.
        vc_req_i = '0;
        applyStimulus(2, mkFlit(HEAD, 32'hF0, 2'b00));
        #1;
        checkOutput("mr_ready_head", FLIT_W'(vc_ready_o), FLIT_W'(3'b100));
        nextCycle();
        checkOutput("mr_fout_head", fout_req_o, mkFlit(HEAD, 32'hF0, 2'd2));
        fout_resp_i = 1'b0;
        applyStimulus(2, mkFlit(BODY, 32'hF1, 2'b00));
        applyStimulus(0, mkFlit(HT, 32'hF9, 2'b00));
        #1;
        checkOutput("mr_ready_locked", FLIT_W'(vc_ready_o), FLIT_W'(3'b100));
        arst = 1'b0;
        #1;
        checkOutput("mr_fout_in_reset", fout_req_o, '0);
        checkOutput("mr_ready_in_reset", FLIT_W'(vc_ready_o), '0);
        nextCycle();
        arst        = 1'b1;
        fout_resp_i = 1'b1;
        #1;
        checkOutput("mr_fout_empty", fout_req_o, '0);
        checkOutput("mr_ready_after", FLIT_W'(vc_ready_o), FLIT_W'(3'b001));
        nextCycle();
        checkOutput("mr_fout_vc0", fout_req_o, mkFlit(HT, 32'hF9, 2'd0));
        vc_req_i = '0;
        nextCycle();
        checkOutput("mr_drained", fout_req_o, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
